// File: rtl/rx_tick_scheduler.sv
// rx_tick_scheduler: frame-aligned oversample/bit tick generator and start/stop qualifier for the UART receiver.
// Optional feature macro RX_MAJORITY_VOTE_EN: 2-of-3 vote over the last three sampled line values.
module rx_tick_scheduler #(
    parameter int DATA_SIZE   = 7,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             receive_line,
    output logic                             sample_tick,
    output logic                             bit_tick_one_and_half,
    output logic                             bit_tick,
    output logic                             sampled_bit,
    output logic [$clog2(DATA_SIZE+1)-1:0]   bit_index,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             frame_error
);

    localparam int SAMPLE_DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int PW         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW         = $clog2(3 * OVERSAMPLE / 2 + 1);
    localparam int IW         = $clog2(DATA_SIZE + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] SC_MID     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SC_HALF    = CW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SC_BIT     = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_SIZE - 1);
    localparam logic [IW-1:0] IDX_STOP   = IW'(DATA_SIZE);

    if (SAMPLE_DIV < 2) begin : g_bad_div
        $error("rx_tick_scheduler: CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("rx_tick_scheduler: OVERSAMPLE must be even and at least 8");
    end
    if (DATA_SIZE < 1 || DATA_SIZE > 16) begin : g_bad_ds
        $error("rx_tick_scheduler: DATA_SIZE must be in 1..16");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH,
        S_BREAK
    } state_t;

    // Line synchronizer, idles high
    logic sync1_q, sync2_q;
    logic sync_line;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= receive_line;
            sync2_q <= sync1_q;
        end
    end

    assign sync_line = sync2_q;

    // Sample-rate prescaler
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = enable && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        if (!enable || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    logic line_val;

`ifdef RX_MAJORITY_VOTE_EN
    logic [2:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (tick) begin
            hist_d = {hist_q[1:0], sync_line};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '1;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Vote over the two previous samples plus the current one, so decisions stay on the tick
    assign line_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_line) | (hist_q[0] & sync_line);
`else
    assign line_val = sync_line;
`endif

    // Frame sequencer
    state_t        state_q, state_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic [IW-1:0] idx_q, idx_d, idx_inc;
    logic          sbit_q, sbit_d;
    logic          half_q, half_d;
    logic          btick_q, btick_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    assign idx_inc = idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        idx_d   = idx_q;
        sbit_d  = sbit_q;
        half_d  = 1'b0;
        btick_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;

        if (!enable) begin
            state_d = S_IDLE;
            scnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick && !sync_line) begin
                        state_d = S_START;
                        scnt_d  = '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (scnt_q == SC_MID && line_val) begin
                            state_d = S_IDLE;
                            scnt_d  = '0;
                        end else if (scnt_q == SC_HALF) begin
                            half_d  = 1'b1;
                            sbit_d  = line_val;
                            idx_d   = '0;
                            scnt_d  = '0;
                            state_d = (DATA_SIZE == 1) ? S_STOP : S_DATA;
                        end else begin
                            scnt_d = scnt_q + CW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (scnt_q == SC_BIT) begin
                            btick_d = 1'b1;
                            sbit_d  = line_val;
                            idx_d   = idx_inc;
                            scnt_d  = '0;
                            if (idx_inc == IDX_LAST) begin
                                state_d = S_STOP;
                            end
                        end else begin
                            scnt_d = scnt_q + CW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (scnt_q == SC_BIT) begin
                            btick_d = 1'b1;
                            sbit_d  = line_val;
                            idx_d   = IDX_STOP;
                            scnt_d  = '0;
                            state_d = S_FINISH;
                        end else begin
                            scnt_d = scnt_q + CW'(1);
                        end
                    end
                end
                // One clock after the stop tick; a low stop bit parks in S_BREAK until the line recovers
                S_FINISH: begin
                    done_d  = 1'b1;
                    err_d   = !sbit_q;
                    state_d = sbit_q ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    if (tick && sync_line) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    scnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            scnt_q  <= '0;
            idx_q   <= '0;
            sbit_q  <= 1'b0;
            half_q  <= 1'b0;
            btick_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
            sbit_q  <= sbit_d;
            half_q  <= half_d;
            btick_q <= btick_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign sample_tick           = tick;
    assign bit_tick_one_and_half = half_q;
    assign bit_tick              = btick_q;
    assign sampled_bit           = sbit_q;
    assign bit_index             = idx_q;
    assign busy                  = (state_q != S_IDLE);
    assign frame_done            = done_q;
    assign frame_error           = err_q;

endmodule
